// File: rtl/noc_flit_packetizer_if.sv
// Core-to-router link bundle for the flit packetizer: the packet request,
// the payload word stream and the outgoing flit channel.
interface noc_flit_packetizer_if;
   logic        req_valid;
   logic        req_ready;
   logic [3:0]  req_dest_x;
   logic [3:0]  req_dest_y;
   logic [7:0]  req_len;
   logic        pld_valid;
   logic        pld_ready;
   logic [61:0] pld_data;
   logic [63:0] flit_out;
   logic        valid_out;
   logic        ready_in;

   // Core/router side: issues requests and payload, sinks flits.
   modport master (
      output req_valid, req_dest_x, req_dest_y, req_len,
      output pld_valid, pld_data, ready_in,
      input  req_ready, pld_ready, flit_out, valid_out
   );

   // Packetizer side.
   modport slave (
      input  req_valid, req_dest_x, req_dest_y, req_len,
      input  pld_valid, pld_data, ready_in,
      output req_ready, pld_ready, flit_out, valid_out
   );
endinterface

// File: rtl/noc_flit_packetizer.sv
// Network-interface transmit packetizer: turns a packet request plus payload
// words into head/body/tail 64-bit flits held in a single output register.
module noc_flit_packetizer #(
   parameter logic [3:0] SRC_X = 4'd0,
   parameter logic [3:0] SRC_Y = 4'd0
) (
   input  logic                        clk,
   input  logic                        rst,
   noc_flit_packetizer_if.slave        link,
   output logic                        busy,
   output logic [7:0]                  pkt_id,
   output logic [15:0]                 pkts_sent
);
   typedef enum logic {IDLE = 1'b0, BODY = 1'b1} state_t;

   state_t      state_reg, state_next;
   logic [7:0]  beat_reg;
   logic [63:0] flit_reg;
   logic        valid_reg;
   logic [7:0]  pkt_id_reg;
   logic [15:0] pkts_sent_reg;

   logic        out_free;
   logic        req_ready;
   logic        pld_ready;
   logic        req_fire;
   logic        pld_fire;
   logic        last_beat;
   logic        len_zero;
   logic [63:0] head_flit;
   logic [63:0] body_flit;

   // The output register can take a new flit when empty or being drained.
   assign out_free  = !valid_reg || link.ready_in;
   assign req_fire  = link.req_valid && req_ready;
   assign pld_fire  = link.pld_valid && pld_ready;
   assign last_beat = (beat_reg == 8'd1);
   assign len_zero  = (link.req_len == 8'd0);

   assign head_flit = {len_zero ? 2'b11 : 2'b01, link.req_dest_x, link.req_dest_y,
                       SRC_X, SRC_Y, link.req_len, pkt_id_reg, 30'd0};
   assign body_flit = {last_beat ? 2'b10 : 2'b00, link.pld_data};

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_reg <= IDLE;
      else     state_reg <= state_next;
   end

   // Next state: a non-empty request opens a packet, the last payload word closes it.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (req_fire && !len_zero) state_next = BODY;
         BODY:    if (pld_fire && last_beat) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Handshake outputs: depend only on state, occupancy and ready_in; held low in reset.
   always_comb begin
      req_ready = 1'b0;
      pld_ready = 1'b0;
      if (!rst) begin
         case (state_reg)
            IDLE:    req_ready = out_free;
            BODY:    pld_ready = out_free;
            default: ;
         endcase
      end
   end

   // Beat counter: loaded with the packet length at accept, counts payload words down.
   always_ff @(posedge clk) begin
      if (rst)           beat_reg <= 8'd0;
      else if (req_fire) beat_reg <= link.req_len;
      else if (pld_fire) beat_reg <= beat_reg - 8'd1;
   end

   // Output flit register: loads on any accept, holds while stalled, empties when drained.
   always_ff @(posedge clk) begin
      if (rst) begin
         flit_reg  <= 64'd0;
         valid_reg <= 1'b0;
      end else if (req_fire) begin
         flit_reg  <= head_flit;
         valid_reg <= 1'b1;
      end else if (pld_fire) begin
         flit_reg  <= body_flit;
         valid_reg <= 1'b1;
      end else if (link.ready_in) begin
         valid_reg <= 1'b0;
      end
   end

   // Packet ID advances once the last flit of a packet has been loaded.
   always_ff @(posedge clk) begin
      if (rst)
         pkt_id_reg <= 8'd0;
      else if ((req_fire && len_zero) || (pld_fire && last_beat))
         pkt_id_reg <= pkt_id_reg + 8'd1;
   end

   // Sent counter: a tail or head-only flit (type bit 63 set) leaving the register.
   always_ff @(posedge clk) begin
      if (rst)
         pkts_sent_reg <= 16'd0;
      else if (valid_reg && link.ready_in && flit_reg[63])
         pkts_sent_reg <= pkts_sent_reg + 16'd1;
   end

   assign link.req_ready = req_ready;
   assign link.pld_ready = pld_ready;
   assign link.flit_out  = flit_reg;
   assign link.valid_out = valid_reg;
   assign busy           = (state_reg != IDLE) || valid_reg;
   assign pkt_id         = pkt_id_reg;
   assign pkts_sent      = pkts_sent_reg;
endmodule

// File: tb/tb_noc_flit_packetizer.sv
// Self-checking bench for noc_flit_packetizer: directed scenarios plus a
// randomized packet stream, scored against an expected-flit queue.
module tb_noc_flit_packetizer;
   localparam logic [3:0] TB_SRC_X = 4'd9;
   localparam logic [3:0] TB_SRC_Y = 4'd6;

   logic        clk = 1'b0;
   logic        rst;
   logic        busy;
   logic [7:0]  pkt_id;
   logic [15:0] pkts_sent;

   noc_flit_packetizer_if link();

   noc_flit_packetizer #(.SRC_X(TB_SRC_X), .SRC_Y(TB_SRC_Y)) dut (
      .clk       (clk),
      .rst       (rst),
      .link      (link),
      .busy      (busy),
      .pkt_id    (pkt_id),
      .pkts_sent (pkts_sent)
   );

   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_fail   = 0;
   int          cyc      = 0;
   int          acc_cyc  = 0;
   int          rdy_mode = 0;      // 0: always ready, 1: random, 2: stalled
   logic [63:0] exp_q[$];
   int          cons_cyc[$];
   logic [7:0]  exp_id     = 8'd0;
   logic [15:0] model_sent = 16'd0;
   logic [63:0] last_head  = 64'd0;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] make_head(input logic [3:0] dx, input logic [3:0] dy,
                                             input logic [7:0] len, input logic [7:0] id);
      logic [1:0] ty;
      ty = (len == 8'd0) ? 2'b11 : 2'b01;
      return {ty, dx, dy, TB_SRC_X, TB_SRC_Y, len, id, 30'd0};
   endfunction

   function automatic logic [61:0] rand62();
      logic [63:0] r;
      r = {$urandom(), $urandom()};
      return r[61:0];
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // Router-side ready generator.
   initial begin
      link.ready_in = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (rdy_mode == 0)      link.ready_in = 1'b1;
         else if (rdy_mode == 2) link.ready_in = 1'b0;
         else                    link.ready_in = ($urandom_range(0, 3) != 0);
      end
   end

   // Output monitor: scores each consumed flit and the sent counter.
   always @(negedge clk) begin
      logic [63:0] e;
      if (!rst) begin
         check_val("pkts_sent", {48'd0, pkts_sent}, {48'd0, model_sent});
         if (link.valid_out && link.ready_in) begin
            if (exp_q.size() == 0) begin
               check_val("spurious_flit", 64'(exp_q.size()), 64'd1);
            end else begin
               e = exp_q.pop_front();
               check_val("flit", link.flit_out, e);
               if (e[63]) model_sent = model_sent + 16'd1;
               if (link.flit_out[62]) last_head = link.flit_out;
               cons_cyc.push_back(cyc);
               $display("flit %h consumed at cycle %0d", link.flit_out, cyc);
            end
         end
      end
   end

   task automatic drive_req(input logic [3:0] dx, input logic [3:0] dy, input logic [7:0] len);
      int guard;
      guard = 0;
      link.req_valid  = 1'b1;
      link.req_dest_x = dx;
      link.req_dest_y = dy;
      link.req_len    = len;
      forever begin
         @(negedge clk);
         if (link.req_ready) break;
         guard++;
         if (guard > 2000) break;
      end
      if (guard > 2000) check_val("req_timeout", 64'(guard), 64'd0);
      else acc_cyc = cyc;
      @(posedge clk);
      #1;
      if (guard <= 2000) begin
         exp_q.push_back(make_head(dx, dy, len, exp_id));
         exp_id = exp_id + 8'd1;
      end
      link.req_valid  = 1'b0;
      link.req_dest_x = 4'($urandom);
      link.req_dest_y = 4'($urandom);
      link.req_len    = 8'($urandom);
   endtask

   task automatic drive_word(input int gap, input logic [61:0] d, input bit last);
      int guard;
      guard = 0;
      repeat (gap) begin
         @(posedge clk);
         #1;
      end
      link.pld_valid = 1'b1;
      link.pld_data  = d;
      forever begin
         @(negedge clk);
         if (link.pld_ready) break;
         guard++;
         if (guard > 2000) break;
      end
      if (guard > 2000) check_val("pld_timeout", 64'(guard), 64'd0);
      @(posedge clk);
      #1;
      if (guard <= 2000) exp_q.push_back({last ? 2'b10 : 2'b00, d});
      link.pld_valid = 1'b0;
      link.pld_data  = rand62();
   endtask

   task automatic send_pkt(input logic [3:0] dx, input logic [3:0] dy, input logic [7:0] len,
                           input int max_gap);
      drive_req(dx, dy, len);
      for (int i = 0; i < int'(len); i++)
         drive_word($urandom_range(0, max_gap), rand62(), (i == int'(len) - 1));
   endtask

   task automatic drain();
      int g;
      g = 0;
      while ((exp_q.size() != 0 || link.valid_out) && g < 3000) begin
         @(negedge clk);
         g++;
      end
      check_val("drain_timeout", 64'(g < 3000), 64'd1);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      exp_q.delete();
      exp_id     = 8'd0;
      model_sent = 16'd0;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      int base;
      rst             = 1'b1;
      link.req_valid  = 1'b0;
      link.req_dest_x = 4'd0;
      link.req_dest_y = 4'd0;
      link.req_len    = 8'd0;
      link.pld_valid  = 1'b0;
      link.pld_data   = 62'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_val("rst_flit",      link.flit_out,          64'd0);
      check_val("rst_valid",     64'(link.valid_out),    64'd0);
      check_val("rst_req_ready", 64'(link.req_ready),    64'd0);
      check_val("rst_pld_ready", 64'(link.pld_ready),    64'd0);
      check_val("rst_busy",      64'(busy),              64'd0);
      check_val("rst_pkt_id",    64'(pkt_id),            64'd0);
      check_val("rst_pkts_sent", 64'(pkts_sent),         64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Basic 3-flit packet to (3,5).
      base = cons_cyc.size();
      drive_req(4'd3, 4'd5, 8'd2);
      drive_word(0, rand62(), 1'b0);
      drive_word(0, rand62(), 1'b1);
      drain();
      check_val("t1_head_top",  64'(last_head[63:56]), 64'h4D);
      check_val("t1_span",      64'(cons_cyc[base+2] - cons_cyc[base]), 64'd2);
      check_val("t1_pkt_id",    64'(pkt_id),    64'(exp_id));
      check_val("t1_pkts_sent", 64'(pkts_sent), 64'd1);

      // Head-only packet.
      base = cons_cyc.size();
      drive_req(4'd1, 4'd2, 8'd0);
      @(negedge clk);
      check_val("t2_req_ready_again", 64'(link.req_ready), 64'd1);
      drain();
      check_val("t2_latency",  64'(cons_cyc[base] - acc_cyc), 64'd1);
      check_val("t2_len_field", 64'(last_head[45:38]), 64'd0);
      check_val("t2_busy",     64'(busy),   64'd0);

      // Payload offered while idle is not taken.
      link.pld_valid = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check_val("idle_pld_ready", 64'(link.pld_ready), 64'd0);
      end
      @(posedge clk);
      #1;
      link.pld_valid = 1'b0;

      // Router stall while the head of a len-4 packet is waiting.
      rdy_mode = 2;
      repeat (2) @(posedge clk);
      #1;
      begin
         logic [63:0] hd;
         hd   = make_head(4'd7, 4'd1, 8'd4, exp_id);
         base = cons_cyc.size();
         drive_req(4'd7, 4'd1, 8'd4);
         link.pld_valid = 1'b1;
         repeat (5) begin
            @(negedge clk);
            check_val("stall_flit",      link.flit_out,          hd);
            check_val("stall_valid",     64'(link.valid_out),    64'd1);
            check_val("stall_pld_ready", 64'(link.pld_ready),    64'd0);
            check_val("stall_busy",      64'(busy),              64'd1);
         end
         rdy_mode = 0;
         for (int i = 0; i < 4; i++) drive_word(0, rand62(), (i == 3));
         drain();
         check_val("stall_release_rate", 64'(cons_cyc[base+4] - cons_cyc[base]), 64'd4);
      end

      // Back-to-back single-word packets.
      base = cons_cyc.size();
      drive_req(4'd2, 4'd2, 8'd1);
      drive_word(0, rand62(), 1'b1);
      drive_req(4'd4, 4'd4, 8'd1);
      drive_word(0, rand62(), 1'b1);
      drain();
      check_val("b2b_span", 64'(cons_cyc[base+3] - cons_cyc[base]), 64'd3);

      // 256 head-only packets: ID wraps back to zero.
      do_reset();
      for (int i = 0; i < 256; i++) drive_req(4'($urandom), 4'($urandom), 8'd0);
      drain();
      check_val("wrap_pkt_id",    64'(pkt_id),    64'(exp_id));
      check_val("wrap_pkts_sent", 64'(pkts_sent), 64'd256);
      drive_req(4'd5, 4'd5, 8'd0);
      drain();
      check_val("wrap_257th_id", 64'(last_head[37:30]), 64'd0);

      // Reset in the middle of a len-3 packet.
      drive_req(4'd1, 4'd1, 8'd3);
      drive_word(0, rand62(), 1'b0);
      do_reset();
      @(negedge clk);
      check_val("mid_rst_valid",     64'(link.valid_out), 64'd0);
      check_val("mid_rst_busy",      64'(busy),           64'd0);
      check_val("mid_rst_pkt_id",    64'(pkt_id),         64'd0);
      check_val("mid_rst_pkts_sent", 64'(pkts_sent),      64'd0);
      @(posedge clk);
      #1;
      send_pkt(4'd6, 4'd3, 8'd2, 0);
      drain();
      check_val("post_rst_sent", 64'(pkts_sent), 64'd1);

      // Randomized packet stream under random router back-pressure.
      rdy_mode = 1;
      for (int p = 0; p < 40; p++)
         send_pkt(4'($urandom), 4'($urandom), 8'($urandom_range(0, 6)), 2);
      rdy_mode = 0;
      drain();
      check_val("rand_pkt_id",    64'(pkt_id),    64'(exp_id));
      check_val("rand_pkts_sent", 64'(pkts_sent), 64'(model_sent));
      check_val("rand_busy",      64'(busy),      64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/noc_flit_packetizer.md
Name: noc_flit_packetizer

Overview:
- Network-interface transmit block. Converts a core-side packet request plus a payload word stream into head, body and tail 64-bit flits.
- Drives the router's local input port over a valid/ready link.
- Sits between a compute-tile DMA/egress queue and router port 0 (local).
- Holds one flit in an output register and sustains one flit per cycle.

Parameters:
- SRC_X, 0, this tile's X coordinate (4-bit range), inserted into every head flit.
- SRC_Y, 0, this tile's Y coordinate (4-bit range), inserted into every head flit.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- req_valid  in  1  packet request valid.
- req_ready  out  1  packet request accepted when req_valid && req_ready.
- req_dest_x  in  4  destination X.
- req_dest_y  in  4  destination Y.
- req_len  in  8  payload flit count, 0..255.
- pld_valid  in  1  payload word valid.
- pld_ready  out  1  payload word accepted when pld_valid && pld_ready.
- pld_data  in  62  payload word.
- flit_out  out  64  flit to router.
- valid_out  out  1  flit valid.
- ready_in  in  1  router can accept the flit.
- busy  out  1  packet in progress (state != IDLE or valid_out).
- pkt_id  out  8  ID to be used by the next head flit.
- pkts_sent  out  16  packets whose final flit was accepted; wraps.

Behaviour:
- Flit format, bits [63:62] type:
  - 01 = head.
  - 00 = body.
  - 10 = tail.
  - 11 = head-only (req_len = 0).
- Head flit fields: [61:58] dest_x, [57:54] dest_y, [53:50] SRC_X, [49:46] SRC_Y, [45:38] len, [37:30] pkt_id, [29:0] zero.
- Body/tail flit: [61:0] = pld_data.
- Reset values: flit_out = 0, valid_out = 0, req_ready = 0, pld_ready = 0, busy = 0, pkt_id = 0, pkts_sent = 0, state = IDLE, beat counter = 0.
- Output register "free" means: !valid_out || ready_in.
- FSM IDLE:
  - req_ready = free.
  - On accept: load the head flit into the output register and set valid_out the next cycle (latency 1).
  - Latch len into the beat counter.
  - If len = 0: head type 11; pkt_id++ at accept; stay IDLE.
  - Else: go to BODY.
- FSM BODY:
  - pld_ready = free.
  - Each accepted word loads a body flit and decrements the counter.
  - The word taken when the counter = 1 is typed tail; return to IDLE and pkt_id++.
  - req_ready = 0 in BODY.
- Back-to-back: the next request can be accepted in the same cycle the tail is being consumed, giving a zero-bubble packet stream.
- Ready must not depend combinationally on req_valid or pld_valid. It may depend on ready_in.
- While valid_out && !ready_in: flit_out and valid_out hold stable.
- valid_out clears only when consumed with no new load.
- pkts_sent increments on the cycle valid_out && ready_in with flit type 10 or 11.
- Wrap rules:
  - pkt_id wraps 255 -> 0.
  - pkts_sent wraps 65535 -> 0.
- pld_valid in IDLE is ignored (not accepted).
- req_len is sampled only at accept; later changes have no effect.
- Reset mid-packet:
  - Everything returns to reset values next cycle, including valid_out = 0.
  - The partial packet is abandoned. The router side tolerates this only under reset.

Test Plan:
- Reset, then req dest (3,5), len 2, ready_in = 1 -> flits 0x4D…(type 01, dest 3/5, len 2, id 0), then type 00 with pld0, then type 10 with pld1 on 3 consecutive cycles; pkts_sent = 1, pkt_id = 1.
- req len 0 -> single flit type 11, bits [45:38] = 0, accepted one cycle after request; pkts_sent += 1; FSM stays IDLE; req_ready is high again the next cycle.
- len 4, ready_in low for 5 cycles while the head is valid -> flit_out/valid_out stable; pld_ready = 0; no payload consumed; on release, remaining flits emitted at 1/cycle.
- Two back-to-back len-1 requests with ready_in = 1 -> head, tail, head, tail with no idle cycle; ids 0 and 1.
- Issue 256 len-0 packets -> the 257th head carries pkt_id 0; pkts_sent = 256.
- Assert rst after the head + 1 body of a len-3 packet -> next cycle valid_out = 0, busy = 0, pkt_id = 0, pkts_sent = 0; a new request completes normally.
